// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Memory-side responder for the multicycle CPU memory port.
//            Accepts one byte-addressed read/write at a time, holds it for a
//            programmable number of wait states, merges byte/halfword stores
//            into the addressed word and returns a one-cycle response.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int c_idx_w = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int c_cnt_w = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [31:0]          c_byte_limit = 32'(4 * DEPTH_WORDS);
  localparam logic [c_cnt_w-1:0]   c_wait_load  = c_cnt_w'(WAIT_CYCLES);
  localparam logic [c_cnt_w-1:0]   c_cnt_one    = c_cnt_w'(1);
  localparam logic [1:0]           c_size_word  = 2'b00;
  localparam logic [1:0]           c_size_byte  = 2'b01;
  localparam logic [1:0]           c_size_half  = 2'b10;
  localparam logic [1:0]           c_size_bad   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_cnt_w-1:0]   r_count;

  logic                 r_wr;
  logic [1:0]           r_size;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;

  logic [31:0]          r_rdata;
  logic                 r_err;

  logic [31:0]          r_mem [DEPTH_WORDS];

  // Effective request: the live inputs on the acceptance edge (needed when
  // there are no wait states), otherwise the latched copy.
  logic                 w_wr;
  logic [1:0]           w_size;
  logic [31:0]          w_addr;
  logic [31:0]          w_wdata;
  logic                 w_err;
  logic [c_idx_w-1:0]   w_idx;
  logic [31:0]          w_old;
  logic [31:0]          w_merged;
  logic                 w_enter_resp;

  assign w_wr    = (r_state == S_IDLE) ? req_wr    : r_wr;
  assign w_size  = (r_state == S_IDLE) ? req_size  : r_size;
  assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

  assign w_idx = w_addr[c_idx_w+1:2];
  assign w_old = r_mem[w_idx];

  // Error classification and lane merge of the request being committed
  always_comb begin
    w_err = 1'b0;
    if (w_addr >= c_byte_limit)                                   w_err = 1'b1;
    if (w_size == c_size_bad)                                     w_err = 1'b1;
    if ((w_size == c_size_half) && w_addr[0])                     w_err = 1'b1;
    if ((w_size == c_size_word) && (w_addr[1:0] != 2'b00))        w_err = 1'b1;

    w_merged = w_old;
    case (w_size)
      c_size_byte: w_merged[{w_addr[1:0], 3'b000} +: 8]  = w_wdata[7:0];
      c_size_half: w_merged[{w_addr[1], 4'b0000} +: 16]  = w_wdata[15:0];
      default:     w_merged = w_wdata;
    endcase
  end

  // Next-state decode and state-derived handshake outputs
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    busy         = 1'b1;
    resp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          w_state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_count <= c_cnt_one) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // The commit edge is the one that moves the FSM into RESP
  assign w_enter_resp = (w_state_next == S_RESP) && (r_state != S_RESP);

  // State, wait counter, request latch and registered response
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_wr    <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if ((r_state == S_IDLE) && req_valid) begin
        r_wr    <= req_wr;
        r_size  <= req_size;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_count <= c_wait_load;
      end else if (r_state == S_WAIT) begin
        r_count <= r_count - c_cnt_one;
      end

      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_wr) ? 32'd0 : w_old;
      end else if (r_state == S_RESP) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end

  // Word array: not reset; a write is blocked while reset is held so an
  // abandoned transaction never commits
  always_ff @(posedge Clk) begin
    if (reset && w_enter_resp && w_wr && !w_err) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
`default_nettype wire
